// File: rtl/data_c_pipe_intc_s2m_lite.sv
// One-to-NUM packet demux, route locked from head beat to last; 1-cycle latency, registered s_ready, full rate via connector + 1-entry overflow buffer.
// Any selected-port stall stalls the block; S2M_ADDR_ERR_EN drops out-of-range packets and pulses o_err_addr instead of clamping to NUM-1.
module data_c_pipe_intc_s2m_lite #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int NSIZE = (NUM <= 2) ? 1 : (NUM <= 4) ? 2 : (NUM <= 8) ? 3 : (NUM <= 16) ? 4 : 5
) (
  input  logic                 i_clock,
  input  logic                 i_rst,
  input  logic [NSIZE-1:0]     i_addr,
  input  logic [DSIZE-1:0]     i_s_data,
  input  logic                 i_s_valid,
  input  logic                 i_s_last,
  output logic                 o_s_ready,
  output logic [NUM*DSIZE-1:0] o_m_data,
  output logic [NUM-1:0]       o_m_valid,
  output logic [NUM-1:0]       o_m_last,
  input  logic [NUM-1:0]       i_m_ready
`ifdef S2M_ADDR_ERR_EN
  ,
  output logic                 o_err_addr
`endif
);

  typedef enum logic {RT_HEAD, RT_BODY} rt_state_e;
  typedef enum logic [1:0] {P_EMPTY, P_CONN, P_FULL} pipe_state_e;

  rt_state_e   r_rt_state, w_rt_next;
  pipe_state_e r_p_state, w_p_next;

  logic [NSIZE-1:0] r_route;
  logic [NSIZE-1:0] w_beat_route;
  logic             w_acc, w_oor, w_push, w_xfer, w_conn_vld;
  logic             w_ld_in, w_ld_buf, w_ld_from_buf;
  logic             r_s_ready;

  logic [DSIZE-1:0] r_conn_data, r_buf_data;
  logic             r_conn_last, r_buf_last;
  logic [NSIZE-1:0] r_conn_route, r_buf_route;

  // Out-of-range addresses only exist when NUM does not fill the addr space.
  generate
    if (NUM == (1 << NSIZE)) begin : g_pow2
      assign w_oor = 1'b0;
    end else begin : g_npow2
      localparam logic [NSIZE:0] NUM_W = (NSIZE+1)'(NUM);
      assign w_oor = ({1'b0, i_addr} >= NUM_W);
    end
  endgenerate

  assign w_acc = i_s_valid & r_s_ready;

`ifdef S2M_ADDR_ERR_EN
  logic r_drop, r_err, w_drop;

  assign w_beat_route = (r_rt_state == RT_HEAD) ? i_addr : r_route;
  assign w_drop       = (r_rt_state == RT_HEAD) ? w_oor : r_drop;
  assign w_push       = w_acc & ~w_drop;
  assign o_err_addr   = r_err;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_drop <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc & (r_rt_state == RT_HEAD) & w_oor;
      if (w_acc && r_rt_state == RT_HEAD) r_drop <= w_oor;
    end
  end
`else
  localparam logic [NSIZE-1:0] LAST_RT = NSIZE'(NUM - 1);

  assign w_beat_route = (r_rt_state == RT_HEAD) ? (w_oor ? LAST_RT : i_addr) : r_route;
  assign w_push       = w_acc;
`endif

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_rt_state <= RT_HEAD;
      r_route    <= '0;
    end else begin
      r_rt_state <= w_rt_next;
      if (w_acc) r_route <= w_beat_route;
    end
  end

  always_comb begin
    w_rt_next = r_rt_state;
    if (w_acc) begin
      case (r_rt_state)
        RT_HEAD: if (!i_s_last) w_rt_next = RT_BODY;
        RT_BODY: if (i_s_last)  w_rt_next = RT_HEAD;
        default: w_rt_next = RT_HEAD;
      endcase
    end
  end

  assign w_conn_vld = (r_p_state != P_EMPTY);
  assign w_xfer     = w_conn_vld & i_m_ready[r_conn_route];

  // Pushes never arrive in FULL because s_ready is already low there.
  always_comb begin
    w_p_next      = r_p_state;
    w_ld_in       = 1'b0;
    w_ld_buf      = 1'b0;
    w_ld_from_buf = 1'b0;
    case (r_p_state)
      P_EMPTY: begin
        if (w_push) begin
          w_ld_in  = 1'b1;
          w_p_next = P_CONN;
        end
      end
      P_CONN: begin
        if (w_push && w_xfer) begin
          w_ld_in = 1'b1;
        end else if (w_push) begin
          w_ld_buf = 1'b1;
          w_p_next = P_FULL;
        end else if (w_xfer) begin
          w_p_next = P_EMPTY;
        end
      end
      P_FULL: begin
        if (w_xfer) begin
          w_ld_from_buf = 1'b1;
          w_p_next      = P_CONN;
        end
      end
      default: w_p_next = P_EMPTY;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_p_state    <= P_EMPTY;
      r_s_ready    <= 1'b0;
      r_conn_data  <= '0;
      r_conn_last  <= 1'b0;
      r_conn_route <= '0;
      r_buf_data   <= '0;
      r_buf_last   <= 1'b0;
      r_buf_route  <= '0;
    end else begin
      r_p_state <= w_p_next;
      r_s_ready <= (w_p_next != P_FULL);
      if (w_ld_in) begin
        r_conn_data  <= i_s_data;
        r_conn_last  <= i_s_last;
        r_conn_route <= w_beat_route;
      end else if (w_ld_from_buf) begin
        r_conn_data  <= r_buf_data;
        r_conn_last  <= r_buf_last;
        r_conn_route <= r_buf_route;
      end
      if (w_ld_buf) begin
        r_buf_data  <= i_s_data;
        r_buf_last  <= i_s_last;
        r_buf_route <= w_beat_route;
      end
    end
  end

  assign o_s_ready = r_s_ready;
  assign o_m_data  = {NUM{r_conn_data}};
  assign o_m_valid = w_conn_vld ? (NUM'(1) << r_conn_route) : '0;
  assign o_m_last  = (w_conn_vld && r_conn_last) ? (NUM'(1) << r_conn_route) : '0;

endmodule
